fp_ack_parser: RTL
==================

# fp_ack_parser

Parametrised acknowledge-packet parser for the optical fingerprint module link. Consumes the byte stream from the UART receiver, frames full response packets (header, address, packet ID, length, confirmation code, payload, checksum), verifies the checksum and reports the result. Sits between the UART RX block and the lock-control logic; the sticky `flag` output supersedes the fixed-sequence matcher used previously.

## Interface
- `ADDR`, 32'hFFFF_FFFF, module address expected in bytes 3..6 (MSB first)
- `MAX_PAYLOAD`, 4, max payload bytes after the confirmation code (≥1)
- `TIMEOUT_CYC`, 1_000_000, idle clocks allowed between bytes inside a packet (≥2)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `rx_data`  in  8  received byte, valid when `rx_valid`=1
- `rx_valid`  in  1  one-cycle strobe per received byte
- `clr`  in  1  clears `flag` to 2'b00
- `busy`  out  1  parser is inside a packet (state ≠ IDLE)
- `ack_valid`  out  1  one-cycle pulse: good packet accepted
- `ack_code`  out  8  confirmation code of last good packet
- `ack_len`  out  16  length field of last good packet
- `ack_payload`  out  8*MAX_PAYLOAD  payload of last good packet, right-aligned
- `cksum_err`  out  1  one-cycle pulse: checksum mismatch
- `frame_err`  out  1  one-cycle pulse: bad PID or length out of range
- `timeout_err`  out  1  one-cycle pulse: inter-byte timeout
- `flag`  out  2  sticky: 01 match OK (code 00), 10 match fail (code 09), 00 none

## Operation
- States: IDLE, HDR1, ADR, PID, LENH, LENL, CODE, PLD, SUMH, SUML. Advance only on `rx_valid`.
- IDLE: 0xEF → HDR1. HDR1: 0x01 → ADR (byte counter 0), else resync.
- ADR: 4 bytes compared with `ADDR` MSB first; mismatch → resync.
- Resync rule (IDLE/HDR1/ADR mismatch): byte 0xEF → HDR1, else IDLE. No error pulse.
- PID: must be 0x07, else `frame_err`, → IDLE.
- LENH/LENL: 16-bit length L. Valid range 3 ≤ L ≤ MAX_PAYLOAD+3; else `frame_err` after LENL, → IDLE.
- CODE: latch code; payload count N = L−3; N=0 → SUMH, else PLD.
- PLD: shift byte in at LSB of a working register cleared at PID; after N bytes → SUMH.
- Checksum: 16-bit modulo sum of PID, LENH, LENL, CODE and all payload bytes. SUMH/SUML received MSB first.
- SUML: match → load `ack_code`, `ack_len`, `ack_payload`, pulse `ack_valid`; mismatch → pulse `cksum_err`, outputs unchanged. Either way → IDLE.
- `flag`: on good packet, code 0x00 → 01, 0x09 → 10, other codes leave it. `clr` → 00; good-packet update wins over simultaneous `clr`.
- Timeout: counter zeroed on every `rx_valid` and in IDLE; reaching TIMEOUT_CYC−1 outside IDLE → `timeout_err`, → IDLE. A byte arriving in the same cycle as expiry is processed, counter cleared, no timeout.

## Timing
- All outputs registered; `ack_valid`/`cksum_err`/`frame_err` assert the cycle after the `rx_valid` of the deciding byte, width one cycle.
- `flag` and `ack_*` change in the same cycle as `ack_valid`.
- Back-to-back packets supported: byte accepted in any cycle, including the cycle `ack_valid` is high.
- Reset: state IDLE, all outputs 0, `ack_payload` 0, counters 0. Reset mid-packet discards it silently.

## Structure
- Package `fp_pkg`: state enum, `FP_HDR`=16'hEF01, `FP_PID_ACK`=8'h07, `FP_CODE_OK`=8'h00, `FP_CODE_NOMATCH`=8'h09.
- Sub-module `fp_byte_timer` (TIMEOUT_CYC param; inputs `clr`, `en`; output `expire`). Rest in one module.

## Test plan
- EF 01 FF FF FF FF 07 00 03 00 00 0A → `ack_valid` pulse, `ack_code`=00, `ack_len`=0003, `flag`=01.
- EF 01 FF FF FF FF 07 00 03 09 00 13 → `ack_valid`, `flag`=10; then `clr` → `flag`=00.
- EF 01 FF FF FF FF 07 00 07 00 00 01 00 50 00 5F → `ack_payload`=32'h0001_0050, `ack_len`=0007, `flag`=01.
- Same as first with checksum 00 0B → `cksum_err` pulse, no `ack_valid`, `flag`/`ack_*` unchanged; length 00 08 (MAX_PAYLOAD=4) → `frame_err` after LENL.
- Garbage 12 EF EF 01 FF FF FF FF 07 00 03 00 00 0A → resync, one good `ack_valid`.
- EF 01 FF then silence TIMEOUT_CYC cycles → `timeout_err` once, `busy`=0; then full valid packet accepted; reset asserted mid-packet → outputs 0, next packet parses normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and protocol constants for the fingerprint
// module acknowledge-packet parser.
package fp_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR1,
        ADR,
        PID,
        LENH,
        LENL,
        CODE,
        PLD,
        SUMH,
        SUML
    } fp_state_e;

    localparam logic [15:0] FP_HDR          = 16'hEF01;
    localparam logic [7:0]  FP_PID_ACK      = 8'h07;
    localparam logic [7:0]  FP_CODE_OK      = 8'h00;
    localparam logic [7:0]  FP_CODE_NOMATCH = 8'h09;

endpackage

// File: rtl/fp_byte_timer.sv
// Inter-byte idle counter; expire is raised while the count sits
// at TIMEOUT_CYC-1 and no clear is requested in the same cycle.
module fp_byte_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/fp_ack_parser.sv
// Frames fingerprint-module acknowledge packets from the UART byte
// stream, verifies the 16-bit checksum and reports the outcome.
module fp_ack_parser
    import fp_pkg::*;
#(
    parameter logic [31:0] ADDR        = 32'hFFFF_FFFF,
    parameter int          MAX_PAYLOAD = 4,
    parameter int          TIMEOUT_CYC = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     clr,
    output logic                     busy,
    output logic                     ack_valid,
    output logic [7:0]               ack_code,
    output logic [15:0]              ack_len,
    output logic [8*MAX_PAYLOAD-1:0] ack_payload,
    output logic                     cksum_err,
    output logic                     frame_err,
    output logic                     timeout_err,
    output logic [1:0]               flag
);

    localparam int PW = 8 * MAX_PAYLOAD;
    localparam int CW = $clog2(MAX_PAYLOAD + 4);
    localparam logic [16:0] LMAX = 17'(MAX_PAYLOAD + 3);

    fp_state_e state_q, state_d, resync;

    logic [CW-1:0] cnt_q, n_q, cnt_inc;
    logic [7:0]    lenh_q, code_q, sumh_q, addr_byte;
    logic [15:0]   len_q, sum_q, len_w;
    logic [PW-1:0] pld_q;
    logic          len_ok, good, sum_bad, frm_bad, tmo;
    logic          expire;

    fp_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rx_valid || state_q == IDLE),
        .en    (state_q != IDLE),
        .expire(expire)
    );

    always_comb begin
        addr_byte = ADDR[31:24];
        unique case (cnt_q[1:0])
            2'd0: addr_byte = ADDR[31:24];
            2'd1: addr_byte = ADDR[23:16];
            2'd2: addr_byte = ADDR[15:8];
            2'd3: addr_byte = ADDR[7:0];
        endcase
    end

    assign len_w   = {lenh_q, rx_data};
    assign len_ok  = (len_w >= 16'd3) && ({1'b0, len_w} <= LMAX);
    assign cnt_inc = CW'(cnt_q + 1'b1);
    assign resync  = (rx_data == FP_HDR[15:8]) ? HDR1 : IDLE;

    always_comb begin
        state_d = state_q;
        good    = 1'b0;
        sum_bad = 1'b0;
        frm_bad = 1'b0;
        tmo     = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                IDLE: if (rx_data == FP_HDR[15:8]) state_d = HDR1;
                HDR1: state_d = (rx_data == FP_HDR[7:0]) ? ADR : resync;
                ADR: begin
                    if (rx_data != addr_byte)   state_d = resync;
                    else if (cnt_q == CW'(3))   state_d = PID;
                end
                PID: begin
                    if (rx_data == FP_PID_ACK) begin
                        state_d = LENH;
                    end else begin
                        frm_bad = 1'b1;
                        state_d = IDLE;
                    end
                end
                LENH: state_d = LENL;
                LENL: begin
                    if (len_ok) begin
                        state_d = CODE;
                    end else begin
                        frm_bad = 1'b1;
                        state_d = IDLE;
                    end
                end
                CODE: state_d = (n_q == '0) ? SUMH : PLD;
                PLD:  if (cnt_inc == n_q) state_d = SUMH;
                SUMH: state_d = SUML;
                SUML: begin
                    good    = ({sumh_q, rx_data} == sum_q);
                    sum_bad = !good;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (expire) begin
            tmo     = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            n_q    <= '0;
            lenh_q <= '0;
            len_q  <= '0;
            code_q <= '0;
            sumh_q <= '0;
            sum_q  <= '0;
            pld_q  <= '0;
        end else if (rx_valid) begin
            unique case (state_q)
                HDR1: cnt_q <= '0;
                ADR:  cnt_q <= cnt_inc;
                PID: begin
                    sum_q <= {8'h00, rx_data};
                    pld_q <= '0;
                end
                LENH: begin
                    lenh_q <= rx_data;
                    sum_q  <= sum_q + {8'h00, rx_data};
                end
                LENL: begin
                    len_q <= len_w;
                    n_q   <= CW'(len_w - 16'd3);
                    sum_q <= sum_q + {8'h00, rx_data};
                end
                CODE: begin
                    code_q <= rx_data;
                    cnt_q  <= '0;
                    sum_q  <= sum_q + {8'h00, rx_data};
                end
                PLD: begin
                    pld_q <= PW'({pld_q, rx_data});
                    cnt_q <= cnt_inc;
                    sum_q <= sum_q + {8'h00, rx_data};
                end
                SUMH: sumh_q <= rx_data;
                default: ;
            endcase
        end
    end

    // Result registers; a good packet's flag update beats a same-cycle clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_valid   <= 1'b0;
            cksum_err   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            ack_code    <= '0;
            ack_len     <= '0;
            ack_payload <= '0;
            flag        <= 2'b00;
        end else begin
            ack_valid   <= good;
            cksum_err   <= sum_bad;
            frame_err   <= frm_bad;
            timeout_err <= tmo;
            if (good) begin
                ack_code    <= code_q;
                ack_len     <= len_q;
                ack_payload <= pld_q;
            end
            if (good && code_q == FP_CODE_OK)           flag <= 2'b01;
            else if (good && code_q == FP_CODE_NOMATCH) flag <= 2'b10;
            else if (clr)                               flag <= 2'b00;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
